// File: rtl/ysyx_23060077_csr_ctrl_pkg.sv
// Shared types and constants for the CSR controller slice.
// Optional feature macro: YSYX_23060077_CSR_RO_CHECK_EN (read-only CSR write check).
package ysyx_23060077_csr_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned F3_WIDTH   = 3;
  localparam int unsigned IDX_WIDTH  = 5;

  // Controller FSM encodings
  typedef enum logic [2:0] {
    CSRC_IDLE  = 3'd0,
    CSRC_READ  = 3'd1,
    CSRC_WRITE = 3'd2,
    CSRC_TRAP  = 3'd3,
    CSRC_RESP  = 3'd4
  } csrc_state_e;

  // Kind of instruction latched at accept
  typedef enum logic [1:0] {
    OP_CSR   = 2'd0,
    OP_ECALL = 2'd1,
    OP_MRET  = 2'd2
  } op_kind_e;

  // funct3 low bits select the write op; bit 2 selects the immediate form
  localparam logic [F3_WIDTH-1:0] CSR_F3_RW = 3'b001;
  localparam logic [F3_WIDTH-1:0] CSR_F3_RS = 3'b010;
  localparam logic [F3_WIDTH-1:0] CSR_F3_RC = 3'b011;

  // addr[11:10] of read-only CSRs
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  // Request fields captured on accept
  typedef struct packed {
    op_kind_e                kind;
    logic [F3_WIDTH-1:0]     funct3;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   rs1_data;
    logic [IDX_WIDTH-1:0]    rs1_idx;
    logic [IDX_WIDTH-1:0]    rd_idx;
  } csr_req_t;

  // ecall wins over mret, mret wins over a CSR op
  function automatic op_kind_e decode_kind(input logic ecall, input logic mret);
    if (ecall) return OP_ECALL;
    if (mret)  return OP_MRET;
    return OP_CSR;
  endfunction

  // True for addresses in the read-only CSR space
  function automatic logic is_ro_addr(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1 -: 2] == CSR_RO_PREFIX;
  endfunction

endpackage

// File: rtl/ysyx_23060077_csr_ctrl_if.sv
// Issue / CSR-file / result bundle for the CSR controller.
// out_illegal exists only when YSYX_23060077_CSR_RO_CHECK_EN is defined.
interface ysyx_23060077_csr_ctrl_if;
  import ysyx_23060077_csr_ctrl_pkg::*;

  // issue side
  logic                  in_valid;
  logic                  in_ready;
  logic [F3_WIDTH-1:0]   in_funct3;
  logic [ADDR_WIDTH-1:0] in_csr_addr;
  logic [DATA_WIDTH-1:0] in_rs1_data;
  logic [IDX_WIDTH-1:0]  in_rs1_idx;
  logic [IDX_WIDTH-1:0]  in_rd_idx;
  logic                  in_ecall;
  logic                  in_mret;
  logic [DATA_WIDTH-1:0] in_pc;

  // CSR file side
  logic [ADDR_WIDTH-1:0] csr_rd_addr;
  logic [DATA_WIDTH-1:0] csr_rd_data;
  logic [ADDR_WIDTH-1:0] csr_wr_addr;
  logic [DATA_WIDTH-1:0] csr_wr_data;
  logic                  csr_sys;
  logic [F3_WIDTH-1:0]   csr_funct3;
  logic                  csr_ecall;
  logic                  csr_mret;
  logic [DATA_WIDTH-1:0] csr_pc;
  logic [DATA_WIDTH-1:0] csr_mtvec;
  logic [DATA_WIDTH-1:0] csr_mepc;

  // result side
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_rd_wen;
  logic [IDX_WIDTH-1:0]  out_rd_idx;
  logic [DATA_WIDTH-1:0] out_rd_data;
  logic                  out_redirect;
  logic [DATA_WIDTH-1:0] out_redirect_pc;
`ifdef YSYX_23060077_CSR_RO_CHECK_EN
  logic                  out_illegal;
`endif

  // Environment view: drives requests, models the CSR file, consumes results
  modport master (
    output in_valid, in_funct3, in_csr_addr, in_rs1_data, in_rs1_idx, in_rd_idx,
    output in_ecall, in_mret, in_pc,
    input  in_ready,
    input  csr_rd_addr, csr_wr_addr, csr_wr_data, csr_sys, csr_funct3,
    input  csr_ecall, csr_mret, csr_pc,
    output csr_rd_data, csr_mtvec, csr_mepc,
    output out_ready,
    input  out_valid, out_rd_wen, out_rd_idx, out_rd_data, out_redirect, out_redirect_pc
`ifdef YSYX_23060077_CSR_RO_CHECK_EN
    , input out_illegal
`endif
  );

  // Controller view
  modport slave (
    input  in_valid, in_funct3, in_csr_addr, in_rs1_data, in_rs1_idx, in_rd_idx,
    input  in_ecall, in_mret, in_pc,
    output in_ready,
    output csr_rd_addr, csr_wr_addr, csr_wr_data, csr_sys, csr_funct3,
    output csr_ecall, csr_mret, csr_pc,
    input  csr_rd_data, csr_mtvec, csr_mepc,
    input  out_ready,
    output out_valid, out_rd_wen, out_rd_idx, out_rd_data, out_redirect, out_redirect_pc
`ifdef YSYX_23060077_CSR_RO_CHECK_EN
    , output out_illegal
`endif
  );

endinterface

// File: rtl/ysyx_23060077_csr_opsel.sv
// Operand select and write-enable decision for a latched CSR instruction.
// The read-only check is enabled by the RO_CHECK parameter, which the top ties
// to YSYX_23060077_CSR_RO_CHECK_EN.
module ysyx_23060077_csr_opsel
  import ysyx_23060077_csr_ctrl_pkg::*;
#(
  parameter bit RO_CHECK = 1'b0
) (
  input  logic [F3_WIDTH-1:0]   funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [IDX_WIDTH-1:0]  rs1_idx_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  wr_en_o,
  output logic                  op_valid_o,
  output logic                  illegal_o
);

  logic is_rw;
  logic is_set_clr;
  logic wr_req;
  logic ro_hit;

  // Decode op, pick register or zimm operand, and gate the strobe
  always_comb begin
    is_rw      = funct3_i[1:0] == CSR_F3_RW[1:0];
    is_set_clr = (funct3_i[1:0] == CSR_F3_RS[1:0]) || (funct3_i[1:0] == CSR_F3_RC[1:0]);
    wr_data_o  = funct3_i[2] ? DATA_WIDTH'(rs1_idx_i) : rs1_data_i;
    // set/clear with x0 or zimm==0 must not touch the CSR; rw always writes
    wr_req     = is_rw || (is_set_clr && (rs1_idx_i != '0));
    ro_hit     = RO_CHECK && wr_req && is_ro_addr(addr_i);
    wr_en_o    = wr_req && !ro_hit;
    op_valid_o = is_rw || is_set_clr;
    illegal_o  = ro_hit;
  end

endmodule

// File: rtl/ysyx_23060077_csr_ctrl.sv
// CSR instruction sequencer between the EXU issue point and the CSR file.
// CSR op: IDLE -> READ -> WRITE -> RESP; ecall/mret: IDLE -> TRAP -> RESP.
// Define YSYX_23060077_CSR_RO_CHECK_EN to block writes to read-only CSRs and
// report them on out_illegal.
module ysyx_23060077_csr_ctrl
  import ysyx_23060077_csr_ctrl_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  ysyx_23060077_csr_ctrl_if.slave  bus
);

`ifdef YSYX_23060077_CSR_RO_CHECK_EN
  localparam bit RoCheck = 1'b1;
`else
  localparam bit RoCheck = 1'b0;
`endif

  csrc_state_e           state_q;
  csr_req_t              req_q;
  csr_req_t              acc_req;
  logic [DATA_WIDTH-1:0] rd_q;

  logic                  in_ready_q;
  logic [ADDR_WIDTH-1:0] csr_rd_addr_q;
  logic [ADDR_WIDTH-1:0] csr_wr_addr_q;
  logic [DATA_WIDTH-1:0] csr_wr_data_q;
  logic                  csr_sys_q;
  logic [F3_WIDTH-1:0]   csr_funct3_q;
  logic                  csr_ecall_q;
  logic                  csr_mret_q;
  logic [DATA_WIDTH-1:0] csr_pc_q;
  logic                  out_valid_q;
  logic                  out_rd_wen_q;
  logic [IDX_WIDTH-1:0]  out_rd_idx_q;
  logic [DATA_WIDTH-1:0] out_rd_data_q;
  logic                  out_redirect_q;
  logic [DATA_WIDTH-1:0] out_redirect_pc_q;
  logic                  out_illegal_q;

  logic [DATA_WIDTH-1:0] sel_wr_data;
  logic                  sel_wr_en;
  logic                  sel_op_valid;
  logic                  sel_illegal;

  // Request snapshot taken on accept
  assign acc_req = '{
    kind:     decode_kind(bus.in_ecall, bus.in_mret),
    funct3:   bus.in_funct3,
    addr:     bus.in_csr_addr,
    rs1_data: bus.in_rs1_data,
    rs1_idx:  bus.in_rs1_idx,
    rd_idx:   bus.in_rd_idx
  };

  ysyx_23060077_csr_opsel #(
    .RO_CHECK (RoCheck)
  ) u_opsel (
    .funct3_i   (req_q.funct3),
    .rs1_data_i (req_q.rs1_data),
    .rs1_idx_i  (req_q.rs1_idx),
    .addr_i     (req_q.addr),
    .wr_data_o  (sel_wr_data),
    .wr_en_o    (sel_wr_en),
    .op_valid_o (sel_op_valid),
    .illegal_o  (sel_illegal)
  );

  // Sequencer: state plus every registered output; strobes default low each cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= CSRC_IDLE;
      req_q             <= '0;
      rd_q              <= '0;
      in_ready_q        <= 1'b1;
      csr_rd_addr_q     <= '0;
      csr_wr_addr_q     <= '0;
      csr_wr_data_q     <= '0;
      csr_sys_q         <= 1'b0;
      csr_funct3_q      <= '0;
      csr_ecall_q       <= 1'b0;
      csr_mret_q        <= 1'b0;
      csr_pc_q          <= '0;
      out_valid_q       <= 1'b0;
      out_rd_wen_q      <= 1'b0;
      out_rd_idx_q      <= '0;
      out_rd_data_q     <= '0;
      out_redirect_q    <= 1'b0;
      out_redirect_pc_q <= '0;
      out_illegal_q     <= 1'b0;
    end else begin
      csr_rd_addr_q <= '0;
      csr_wr_addr_q <= '0;
      csr_wr_data_q <= '0;
      csr_sys_q     <= 1'b0;
      csr_funct3_q  <= '0;
      csr_ecall_q   <= 1'b0;
      csr_mret_q    <= 1'b0;
      csr_pc_q      <= '0;

      case (state_q)
        CSRC_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            req_q      <= acc_req;
            in_ready_q <= 1'b0;
            case (acc_req.kind)
              OP_ECALL: begin
                state_q     <= CSRC_TRAP;
                csr_ecall_q <= 1'b1;
                csr_pc_q    <= bus.in_pc;
              end
              OP_MRET: begin
                state_q    <= CSRC_TRAP;
                csr_mret_q <= 1'b1;
              end
              default: begin
                state_q       <= CSRC_READ;
                csr_rd_addr_q <= bus.in_csr_addr;
              end
            endcase
          end
        end

        CSRC_READ: begin
          rd_q          <= bus.csr_rd_data;
          csr_sys_q     <= sel_wr_en;
          csr_wr_addr_q <= req_q.addr;
          csr_wr_data_q <= sel_wr_data;
          csr_funct3_q  <= req_q.funct3;
          state_q       <= CSRC_WRITE;
        end

        CSRC_WRITE: begin
          out_valid_q   <= 1'b1;
          out_rd_wen_q  <= sel_op_valid && !sel_illegal && (req_q.rd_idx != '0);
          out_rd_idx_q  <= req_q.rd_idx;
          out_rd_data_q <= rd_q;
          out_illegal_q <= sel_illegal;
          state_q       <= CSRC_RESP;
        end

        CSRC_TRAP: begin
          out_valid_q       <= 1'b1;
          out_rd_wen_q      <= 1'b0;
          out_rd_idx_q      <= req_q.rd_idx;
          out_redirect_q    <= 1'b1;
          out_redirect_pc_q <= (req_q.kind == OP_ECALL) ? bus.csr_mtvec : bus.csr_mepc;
          state_q           <= CSRC_RESP;
        end

        CSRC_RESP: begin
          if (bus.out_ready) begin
            out_valid_q       <= 1'b0;
            out_rd_wen_q      <= 1'b0;
            out_rd_idx_q      <= '0;
            out_rd_data_q     <= '0;
            out_redirect_q    <= 1'b0;
            out_redirect_pc_q <= '0;
            out_illegal_q     <= 1'b0;
            in_ready_q        <= 1'b1;
            state_q           <= CSRC_IDLE;
          end
        end

        default: begin
          state_q    <= CSRC_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Output drive from registers
  assign bus.in_ready        = in_ready_q;
  assign bus.csr_rd_addr     = csr_rd_addr_q;
  assign bus.csr_wr_addr     = csr_wr_addr_q;
  assign bus.csr_wr_data     = csr_wr_data_q;
  assign bus.csr_sys         = csr_sys_q;
  assign bus.csr_funct3      = csr_funct3_q;
  assign bus.csr_ecall       = csr_ecall_q;
  assign bus.csr_mret        = csr_mret_q;
  assign bus.csr_pc          = csr_pc_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_rd_wen      = out_rd_wen_q;
  assign bus.out_rd_idx      = out_rd_idx_q;
  assign bus.out_rd_data     = out_rd_data_q;
  assign bus.out_redirect    = out_redirect_q;
  assign bus.out_redirect_pc = out_redirect_pc_q;
`ifdef YSYX_23060077_CSR_RO_CHECK_EN
  assign bus.out_illegal     = out_illegal_q;
`else
  // Without the check the illegal flag can never be raised
  logic unused_illegal;
  assign unused_illegal = out_illegal_q;
`endif

endmodule

// File: tb/tb_ysyx_23060077_csr_ctrl.sv
// Bench for ysyx_23060077_csr_ctrl: instruction-level model plus a CSR file model.
// Honours YSYX_23060077_CSR_RO_CHECK_EN when defined.
module tb_ysyx_23060077_csr_ctrl;
  import ysyx_23060077_csr_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_23060077_csr_ctrl_if bus ();

  ysyx_23060077_csr_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CSR file model driven by the DUT's strobes
  logic [31:0] csr_mem [4096];
  logic [31:0] gold    [4096];
  int sys_writes = 0;
  int exp_sys_total = 0;

  assign bus.csr_rd_data = csr_mem[bus.csr_rd_addr];
  assign bus.csr_mtvec   = csr_mem[12'h305];
  assign bus.csr_mepc    = csr_mem[12'h341];

  always @(posedge clock) begin
    if (!reset) begin
      if (bus.csr_sys) begin
        sys_writes++;
        case (bus.csr_funct3[1:0])
          2'b01:   csr_mem[bus.csr_wr_addr] <= bus.csr_wr_data;
          2'b10:   csr_mem[bus.csr_wr_addr] <= csr_mem[bus.csr_wr_addr] | bus.csr_wr_data;
          2'b11:   csr_mem[bus.csr_wr_addr] <= csr_mem[bus.csr_wr_addr] & ~bus.csr_wr_data;
          default: ;
        endcase
      end
      if (bus.csr_ecall) begin
        csr_mem[12'h341] <= bus.csr_pc;
        csr_mem[12'h342] <= 32'd11;
      end
    end
  end

  // Expected response of one instruction
  typedef struct {
    logic [31:0] rd_data;
    logic [4:0]  rd_idx;
    logic        rd_wen;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        illegal;
    int          latency;
    int          n_sys;
    int          n_ecall;
    int          n_mret;
    logic [31:0] pc;
  } exp_t;
  exp_t expq[$];

  int cyc = 0;
  always @(posedge clock) cyc++;

  int acc_cyc = 0;
  int xfer_cyc = -10;
  int c_sys, c_ec, c_mr;
  bit chk_b2b = 1'b0;
  bit prev_valid = 1'b0, prev_ready = 1'b0;
  logic [31:0] snap_rd_data, snap_rpc;
  logic [6:0]  snap_flags;
  logic [31:0] last_rd_data, last_rpc;
  logic        last_rd_wen, last_redirect;

  // Compare process: protocol, latency and per-response checks
  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc = cyc;
        c_sys = 0; c_ec = 0; c_mr = 0;
        if (chk_b2b) begin
          check("accept_after_transfer", 64'(cyc), 64'(xfer_cyc + 1));
          chk_b2b = 1'b0;
        end
      end
      if (bus.csr_sys) c_sys++;
      if (bus.csr_mret) c_mr++;
      if (bus.csr_ecall) begin
        c_ec++;
        if (expq.size() > 0) check("ecall_pc", 64'(bus.csr_pc), 64'(expq[0].pc));
      end
      if (bus.csr_sys || bus.csr_ecall || bus.csr_mret)
        check("strobe_onehot", 64'($countones({bus.csr_sys, bus.csr_ecall, bus.csr_mret})), 64'd1);

      if (bus.out_valid) begin
        if (prev_valid && !prev_ready) begin
          check("stall_rd_data", 64'(bus.out_rd_data), 64'(snap_rd_data));
          check("stall_redirect_pc", 64'(bus.out_redirect_pc), 64'(snap_rpc));
          check("stall_flags", 64'({bus.out_rd_wen, bus.out_rd_idx, bus.out_redirect}), 64'(snap_flags));
          check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end else if (expq.size() == 0) begin
          check("unexpected_response", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = expq[0];
          check("latency", 64'(cyc - acc_cyc), 64'(e.latency));
          check("rd_wen", 64'(bus.out_rd_wen), 64'(e.rd_wen));
          check("rd_idx", 64'(bus.out_rd_idx), 64'(e.rd_idx));
          check("rd_data", 64'(bus.out_rd_data), 64'(e.rd_data));
          check("redirect", 64'(bus.out_redirect), 64'(e.redirect));
          check("redirect_pc", 64'(bus.out_redirect_pc), 64'(e.redirect_pc));
          check("sys_pulses", 64'(c_sys), 64'(e.n_sys));
          check("ecall_pulses", 64'(c_ec), 64'(e.n_ecall));
          check("mret_pulses", 64'(c_mr), 64'(e.n_mret));
`ifdef YSYX_23060077_CSR_RO_CHECK_EN
          check("illegal", 64'(bus.out_illegal), 64'(e.illegal));
`endif
          last_rd_data  = bus.out_rd_data;
          last_rpc      = bus.out_redirect_pc;
          last_rd_wen   = bus.out_rd_wen;
          last_redirect = bus.out_redirect;
        end
        snap_rd_data = bus.out_rd_data;
        snap_rpc     = bus.out_redirect_pc;
        snap_flags   = {bus.out_rd_wen, bus.out_rd_idx, bus.out_redirect};
        if (bus.out_ready) begin
          if (expq.size() > 0) void'(expq.pop_front());
          xfer_cyc = cyc;
        end
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
    end
  end

  // Instruction-level model, then drive one request through the handshake
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1d,
                       input logic [4:0] rs1i, input logic [4:0] rd, input logic ec,
                       input logic mr, input logic [31:0] pc, input bit track);
    exp_t e;
    logic [31:0] old, opnd;
    bit kind_ok, wr, ill;
    int w;
    e.rd_data = '0; e.rd_idx = rd; e.rd_wen = 1'b0; e.redirect = 1'b0;
    e.redirect_pc = '0; e.illegal = 1'b0; e.latency = 3; e.n_sys = 0;
    e.n_ecall = 0; e.n_mret = 0; e.pc = pc;
    if (track) begin
      if (ec) begin
        e.redirect = 1'b1; e.redirect_pc = gold[12'h305]; e.latency = 2; e.n_ecall = 1;
        gold[12'h341] = pc;
        gold[12'h342] = 32'd11;
      end else if (mr) begin
        e.redirect = 1'b1; e.redirect_pc = gold[12'h341]; e.latency = 2; e.n_mret = 1;
      end else begin
        old     = gold[addr];
        opnd    = f3[2] ? {27'd0, rs1i} : rs1d;
        kind_ok = f3[1:0] != 2'b00;
        wr      = kind_ok && (f3[1:0] == 2'b01 || rs1i != 5'd0);
        ill     = 1'b0;
`ifdef YSYX_23060077_CSR_RO_CHECK_EN
        if (wr && addr[11:10] == 2'b11) begin
          ill = 1'b1;
          wr  = 1'b0;
        end
`endif
        if (wr) begin
          if (f3[1:0] == 2'b01)      gold[addr] = opnd;
          else if (f3[1:0] == 2'b10) gold[addr] = old | opnd;
          else                       gold[addr] = old & ~opnd;
          exp_sys_total++;
        end
        e.rd_data = old;
        e.rd_wen  = kind_ok && !ill && rd != 5'd0;
        e.n_sys   = wr ? 1 : 0;
        e.illegal = ill;
      end
      expq.push_back(e);
    end
    w = 0;
    do begin
      @(posedge clock);
      #1;
      w++;
    end while (!bus.in_ready && w < 50);
    if (!bus.in_ready) check("issue_wait_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_funct3   = f3;
    bus.in_csr_addr = addr;
    bus.in_rs1_data = rs1d;
    bus.in_rs1_idx  = rs1i;
    bus.in_rd_idx   = rd;
    bus.in_ecall    = ec;
    bus.in_mret     = mr;
    bus.in_pc       = pc;
    bus.in_valid    = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_ecall = 1'b0;
    bus.in_mret  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (expq.size() != 0 && w < 100) begin
      @(posedge clock);
      w++;
    end
    #1;
    check("drain_timeout", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    logic [11:0] chk_addr [6];
    int w;
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = '0;
      gold[i]    = '0;
    end
    csr_mem[12'h300] = 32'h0000_1800; gold[12'h300] = 32'h0000_1800;
    csr_mem[12'h305] = 32'h1000_0000; gold[12'h305] = 32'h1000_0000;
    csr_mem[12'h340] = 32'h0000_1100; gold[12'h340] = 32'h0000_1100;
    csr_mem[12'hF11] = 32'h0000_0602; gold[12'hF11] = 32'h0000_0602;

    bus.in_valid = 1'b0; bus.in_funct3 = '0; bus.in_csr_addr = '0; bus.in_rs1_data = '0;
    bus.in_rs1_idx = '0; bus.in_rd_idx = '0; bus.in_ecall = 1'b0; bus.in_mret = 1'b0;
    bus.in_pc = '0; bus.out_ready = 1'b1;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_strobes", 64'({bus.csr_sys, bus.csr_ecall, bus.csr_mret}), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // csrrw mtvec, x1=0x80000100, rd=x5
    issue(3'b001, 12'h305, 32'h8000_0100, 5'd1, 5'd5, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();
    check("lit_csrrw_old_mtvec", 64'(last_rd_data), 64'h1000_0000);
    check("lit_mtvec_written", 64'(csr_mem[12'h305]), 64'h8000_0100);

    // csrrs mstatus, x0 (junk rs1 data must not be written), rd=x6
    issue(3'b010, 12'h300, 32'hDEAD_BEEF, 5'd0, 5'd6, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();
    check("lit_csrrs_mstatus", 64'(last_rd_data), 64'h0000_1800);
    check("lit_csrrs_rd_wen", 64'(last_rd_wen), 64'd1);

    // ecall
    issue(3'b000, 12'h000, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h8000_0040, 1'b1);
    drain();
    check("lit_ecall_target", 64'(last_rpc), 64'h8000_0100);
    check("lit_mepc", 64'(csr_mem[12'h341]), 64'h8000_0040);
    check("lit_mcause", 64'(csr_mem[12'h342]), 64'd11);

    // csrrw mepc with rd=x0 still writes; then mret
    issue(3'b001, 12'h341, 32'h8000_0044, 5'd2, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(3'b000, 12'h000, 32'h0, 5'd0, 5'd3, 1'b0, 1'b1, 32'h8000_0080, 1'b1);
    drain();
    check("lit_mret_target", 64'(last_rpc), 64'h8000_0044);
    check("lit_mret_rd_wen", 64'(last_rd_wen), 64'd0);

    // csrrs / csrrc on mscratch
    issue(3'b010, 12'h340, 32'h0000_0F0F, 5'd3, 5'd7, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();
    check("lit_mscratch_set", 64'(csr_mem[12'h340]), 64'h0000_1F0F);

    // csrrc with response stalled, then back-to-back accept
    bus.out_ready = 1'b0;
    issue(3'b011, 12'h340, 32'h0000_0003, 5'd4, 5'd8, 1'b0, 1'b0, 32'h0, 1'b1);
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(posedge clock);
      #1;
      w++;
    end
    check("stall_resp_seen", 64'(bus.out_valid), 64'd1);
    repeat (5) @(posedge clock);
    #1;
    check("stall_in_ready_low", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    chk_b2b = 1'b1;
    issue(3'b110, 12'h340, 32'hFFFF_FFFF, 5'd5, 5'd9, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();
    check("lit_csrrsi_old", 64'(last_rd_data), 64'h0000_1F0C);
    check("lit_mscratch_imm", 64'(csr_mem[12'h340]), 64'h0000_1F0D);

    // csrrci zimm=0 (no write), csrrwi zimm=0x1f, unused funct3 000
    issue(3'b111, 12'h340, 32'hFFFF_FFFF, 5'd0, 5'd10, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(3'b101, 12'h340, 32'hFFFF_FFFF, 5'd31, 5'd11, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(3'b000, 12'h340, 32'h1234_5678, 5'd6, 5'd12, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(3'b100, 12'h340, 32'h1234_5678, 5'd6, 5'd12, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();
    check("lit_unused_rd_wen", 64'(last_rd_wen), 64'd0);
    check("lit_unused_rd_data", 64'(last_rd_data), 64'h0000_001F);

    // priority: ecall over mret, mret over a CSR op
    issue(3'b001, 12'h340, 32'hAAAA_0000, 5'd1, 5'd13, 1'b1, 1'b1, 32'h8000_0200, 1'b1);
    issue(3'b001, 12'h340, 32'hBBBB_0000, 5'd1, 5'd14, 1'b0, 1'b1, 32'h8000_0300, 1'b1);
    drain();
    check("lit_mret_prio_target", 64'(last_rpc), 64'h8000_0200);

    // write to a read-only CSR
    issue(3'b001, 12'hF11, 32'h0000_00AA, 5'd1, 5'd15, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();

    // reset while the write strobe is up: outputs clear without a clock edge
    issue(3'b001, 12'h340, 32'hCAFE_F00D, 5'd1, 5'd16, 1'b0, 1'b0, 32'h0, 1'b0);
    w = 0;
    while (!bus.csr_sys && w < 10) begin
      @(negedge clock);
      w++;
    end
    check("reset_test_sys_seen", 64'(bus.csr_sys), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_sys", 64'(bus.csr_sys), 64'd0);
    check("midreset_wr_data", 64'(bus.csr_wr_data), 64'd0);
    check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    check("midreset_all_zero", 64'(|{bus.csr_rd_addr, bus.csr_wr_addr, bus.csr_wr_data, bus.csr_sys,
                                      bus.csr_funct3, bus.csr_ecall, bus.csr_mret, bus.csr_pc,
                                      bus.out_valid, bus.out_rd_wen, bus.out_rd_idx, bus.out_rd_data,
                                      bus.out_redirect, bus.out_redirect_pc}), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // recovery
    issue(3'b010, 12'h340, 32'h0000_4000, 5'd2, 5'd17, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();
    repeat (3) @(posedge clock);
    #1;

    chk_addr = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF11};
    foreach (chk_addr[i]) check($sformatf("csr_final_%03h", chk_addr[i]),
                                64'(csr_mem[chk_addr[i]]), 64'(gold[chk_addr[i]]));
    check("sys_write_count", 64'(sys_writes), 64'(exp_sys_total));
    check("out_valid_idle", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
